// File: rtl/core_pkg.sv
// Core-wide parameters and types shared by the load/store unit.
package core_pkg;

  localparam int Xlen = 32;
  localparam int NB   = Xlen / 8;
  localparam int OffW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_e;
  typedef enum logic [1:0] {Byte, Half, Word, Double} memsize_e;

  function automatic int size_bytes(memsize_e s);
    return 1 << int'(s);
  endfunction

  // Double-width codes only exist on a 64-bit core.
  function automatic logic op_legal(logic store, logic [2:0] f3);
    if (store)
      return (f3[2] == 1'b0) && ((f3[1:0] != 2'd3) || (Xlen == 64));
    else
      return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
             ((Xlen == 64) && (f3 inside {3'd3, 3'd6}));
  endfunction

  function automatic logic op_aligned(logic [2:0] low, memsize_e s);
    case (s)
      Byte:    return 1'b1;
      Half:    return low[0] == 1'b0;
      Word:    return low[1:0] == 2'b00;
      default: return low == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes from a memory word and sign/zero-extends them.
module lsu_load_align
  import core_pkg::*;
(
  input  logic [Xlen-1:0] rdata,
  input  logic [OffW-1:0] off,
  input  logic [2:0]      funct3,
  output logic [Xlen-1:0] data
);

  logic [Xlen-1:0] shifted;
  logic            fill;
  int              bits;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    bits    = 8 * size_bytes(memsize_e'(funct3[1:0]));
    if (bits > Xlen) bits = Xlen;
    fill = 1'b0;
    for (int i = 0; i < Xlen; i++)
      if (i == bits - 1) fill = shifted[i];
    fill = fill & ~funct3[2];
    data = '0;
    for (int i = 0; i < Xlen; i++)
      data[i] = (i < bits) ? shifted[i] : fill;
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: accepts one op, issues one memory
// request, and holds the result until writeback takes it.
module lsu
  import core_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            store_i,
  input  logic [2:0]      funct3_i,
  input  logic [Xlen-1:0] addr_i,
  input  logic [Xlen-1:0] wdata_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [Xlen-1:0] rdata_o,
  output logic            misaligned_o,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic            mem_we_o,
  output logic [Xlen-1:0] mem_addr_o,
  output logic [Xlen-1:0] mem_wdata_o,
  output logic [NB-1:0]   mem_wstrb_o,
  input  logic            mem_rvalid_i,
  input  logic [Xlen-1:0] mem_rdata_i
);

  lsu_state_e      state_q, state_d;
  logic            store_q;
  logic [2:0]      funct3_q;
  logic [Xlen-1:0] addr_q, wdata_q, rdata_q, load_data;
  logic            mis_q;
  logic [OffW-1:0] off;
  logic [NB-1:0]   size_mask;
  logic            accept, op_ok;

  assign off   = addr_q[OffW-1:0];
  assign op_ok = op_legal(store_i, funct3_i) &&
                 op_aligned(addr_i[2:0], memsize_e'(funct3_i[1:0]));

  always_comb begin
    size_mask = '0;
    for (int i = 0; i < NB; i++)
      size_mask[i] = (i < size_bytes(memsize_e'(funct3_q[1:0])));
  end

  lsu_load_align u_align (
    .rdata  (mem_rdata_i),
    .off    (off),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    mem_valid_o = 1'b0;
    mem_we_o    = 1'b0;
    mem_wstrb_o = '0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          accept  = 1'b1;
          state_d = op_ok ? REQ : DONE;
        end
      end
      REQ: begin
        mem_valid_o = 1'b1;
        mem_we_o    = store_q;
        mem_wstrb_o = size_mask << off;
        if (mem_ready_i) state_d = store_q ? DONE : RESP;
      end
      RESP: begin
        if (mem_rvalid_i) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o   = {addr_q[Xlen-1:OffW], {OffW{1'b0}}};
  assign mem_wdata_o  = wdata_q << {off, 3'b000};
  assign rdata_o      = rdata_q;
  assign misaligned_o = mis_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q  <= store_i;
        funct3_q <= funct3_i;
        addr_q   <= addr_i;
        wdata_q  <= wdata_i;
        rdata_q  <= '0;
        mis_q    <= ~op_ok;
      end else if (state_q == RESP && mem_rvalid_i) begin
        rdata_q <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed bench for the LSU against a byte-arithmetic model.
module tb_lsu;
  import core_pkg::*;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            valid_i, ready_o, store_i;
  logic [2:0]      funct3_i;
  logic [Xlen-1:0] addr_i, wdata_i;
  logic            valid_o, ready_i;
  logic [Xlen-1:0] rdata_o;
  logic            misaligned_o;
  logic            mem_valid_o, mem_ready_i, mem_we_o;
  logic [Xlen-1:0] mem_addr_o, mem_wdata_o;
  logic [NB-1:0]   mem_wstrb_o;
  logic            mem_rvalid_i;
  logic [Xlen-1:0] mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .store_i      (store_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .rdata_o      (rdata_o),
    .misaligned_o (misaligned_o),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain byte arithmetic over the access rules.
  function automatic bit m_legal(bit st, int f3);
    if (st) return (f3 <= 2) || (Xlen == 64 && f3 == 3);
    return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) ||
           (Xlen == 64 && (f3 == 3 || f3 == 6));
  endfunction

  function automatic int m_bytes(int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [Xlen-1:0] m_load(logic [Xlen-1:0] word, int off, int f3);
    logic [Xlen-1:0] v, mask;
    int bits;
    bits = 8 * m_bytes(f3);
    v = word >> (off * 8);
    if (bits < Xlen) begin
      mask = (Xlen'(1) << bits) - 1;
      v = v & mask;
      if (f3 < 4 && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic do_op(bit st, int f3, logic [Xlen-1:0] addr, logic [Xlen-1:0] wdata,
                       logic [Xlen-1:0] rdata, int req_wait, int done_wait);
    bit ok;
    int off;
    logic [Xlen-1:0] e_addr, e_wdata, e_rdata;
    logic [NB-1:0] e_strb;
    ok      = m_legal(st, f3) && ((addr % m_bytes(f3)) == 0);
    off     = int'(addr % NB);
    e_addr  = addr - Xlen'(off);
    e_wdata = wdata << (off * 8);
    e_strb  = NB'(((64'd1 << m_bytes(f3)) - 1) << off);
    e_rdata = st ? '0 : m_load(rdata, off, f3);

    check("idle_ready", ready_o, 1'b1);
    valid_i = 1'b1; store_i = st; funct3_i = 3'(f3); addr_i = addr; wdata_i = wdata;
    @(negedge clk);
    valid_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; funct3_i = 3'($urandom);
    check("busy_ready", ready_o, 1'b0);

    if (!ok) begin
      check("bad_valid", valid_o, 1'b1);
      check("bad_mis", misaligned_o, 1'b1);
      check("bad_memvalid", mem_valid_o, 1'b0);
      check("bad_strb", mem_wstrb_o, '0);
    end else begin
      for (int w = 0; w <= req_wait; w++) begin
        check("req_valid", mem_valid_o, 1'b1);
        check("req_we", mem_we_o, st);
        check("req_addr", mem_addr_o, e_addr);
        check("req_strb", mem_wstrb_o, e_strb);
        if (st) check("req_wdata", mem_wdata_o, e_wdata);
        check("req_outvalid", valid_o, 1'b0);
        mem_ready_i  = (w == req_wait);
        mem_rvalid_i = 1'($urandom);
        @(negedge clk);
      end
      mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
      if (!st) begin
        check("resp_valid", valid_o, 1'b0);
        check("resp_memvalid", mem_valid_o, 1'b0);
        check("resp_strb", mem_wstrb_o, '0);
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
        @(negedge clk);
        mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
      end
      check("done_valid", valid_o, 1'b1);
      check("done_mis", misaligned_o, 1'b0);
      check("done_rdata", rdata_o, e_rdata);
    end

    for (int d = 0; d < done_wait; d++) begin
      valid_i = 1'b1; store_i = 1'($urandom); funct3_i = 3'($urandom); addr_i = $urandom;
      ready_i = 1'b0; mem_rvalid_i = 1'($urandom);
      @(negedge clk);
      check("hold_valid", valid_o, 1'b1);
      check("hold_ready", ready_o, 1'b0);
      check("hold_mis", misaligned_o, !ok);
      if (ok) check("hold_rdata", rdata_o, e_rdata);
      check("hold_memvalid", mem_valid_o, 1'b0);
    end
    valid_i = 1'b0; mem_rvalid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("ret_valid", valid_o, 1'b0);
    check("ret_ready", ready_o, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; store_i = 1'b0; funct3_i = 3'd0; addr_i = '0; wdata_i = '0;
    ready_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", valid_o, 1'b0);
    check("rst_memvalid", mem_valid_o, 1'b0);
    check("rst_we", mem_we_o, 1'b0);
    check("rst_strb", mem_wstrb_o, '0);
    check("rst_rdata", rdata_o, '0);
    check("rst_mis", misaligned_o, 1'b0);
    rst_i = 1'b0;
    @(negedge clk);

    do_op(1'b0, 0, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0, 0);  // LB
    do_op(1'b1, 1, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 0);  // SH
    do_op(1'b0, 2, 32'h0000_1001, 32'h0, 32'h0, 0, 0);          // LW misaligned
    do_op(1'b0, 5, 32'h0000_0010, 32'h0, 32'h1234_8765, 3, 0);  // LHU stalled
    do_op(1'b0, 2, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 4);  // LW, writeback stall
    do_op(1'b1, 3, 32'h0000_0200, 32'h1111_2222, 32'h0, 0, 1);  // illegal SD on 32-bit
    do_op(1'b0, 7, 32'h0000_0300, 32'h0, 32'h0, 0, 0);          // illegal load code

    // Reset while waiting for the read response.
    valid_i = 1'b1; store_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h40;
    @(negedge clk);
    valid_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk);
    mem_ready_i = 1'b0;
    check("mid_valid", valid_o, 1'b0);
    check("mid_ready", ready_o, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    check("arst_ready", ready_o, 1'b1);
    check("arst_valid", valid_o, 1'b0);
    check("arst_memvalid", mem_valid_o, 1'b0);
    check("arst_we", mem_we_o, 1'b0);
    check("arst_strb", mem_wstrb_o, '0);
    check("arst_rdata", rdata_o, '0);
    check("arst_mis", misaligned_o, 1'b0);
    #1 rst_i = 1'b0;
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check("late_rvalid_valid", valid_o, 1'b0);
    check("late_rvalid_ready", ready_o, 1'b1);
    check("late_rvalid_rdata", rdata_o, '0);

    for (int n = 0; n < 60; n++) begin
      bit st;
      int f3;
      logic [Xlen-1:0] a;
      st = 1'($urandom);
      f3 = int'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~Xlen'(m_bytes(f3) - 1);
      do_op(st, f3, a, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
